// File: rtl/cell_perm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cell_perm_pkg
// Brief   : Cell count, permutation tables and mode encoding for the engine.
// Revision: 1.0 - initial release
// ============================================================================
package cell_perm_pkg;

    localparam int NUM_CELLS = 16;

    typedef enum logic [1:0] {
        PERM_FWD = 2'd0,
        PERM_INV = 2'd1,
        PERM_TWK = 2'd2,
        PERM_ID  = 2'd3
    } perm_mode_e;

    // Entry i names the source cell for output cell i.
    localparam logic [3:0] TBL_P [NUM_CELLS] = '{
        4'h0, 4'hb, 4'h6, 4'hd, 4'ha, 4'h1, 4'hc, 4'h7,
        4'h5, 4'he, 4'h3, 4'h8, 4'hf, 4'h4, 4'h9, 4'h2
    };
    localparam logic [3:0] TBL_P_INV [NUM_CELLS] = '{
        4'h0, 4'h5, 4'hf, 4'ha, 4'hd, 4'h8, 4'h2, 4'h7,
        4'hb, 4'he, 4'h4, 4'h1, 4'h6, 4'h3, 4'h9, 4'hc
    };
    localparam logic [3:0] TBL_H [NUM_CELLS] = '{
        4'h6, 4'h5, 4'he, 4'hf, 4'h0, 4'h1, 4'h2, 4'h3,
        4'h7, 4'hc, 4'hd, 4'h4, 4'h8, 4'h9, 4'ha, 4'hb
    };

    function automatic logic [3:0] perm_src(input perm_mode_e mode, input logic [3:0] idx);
        case (mode)
            PERM_FWD: perm_src = TBL_P[idx];
            PERM_INV: perm_src = TBL_P_INV[idx];
            PERM_TWK: perm_src = TBL_H[idx];
            default:  perm_src = idx;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_perm_step.sv
`default_nettype none
// ============================================================================
// Module  : cell_perm_step
// Brief   : One combinational table-driven cell permutation step.
// Revision: 1.0 - initial release
// ============================================================================
module cell_perm_step
    import cell_perm_pkg::*;
#(
    parameter int CELL_W = 4
) (
    input  logic [NUM_CELLS*CELL_W-1:0] data_in,
    input  logic [1:0]                  mode,
    output logic [NUM_CELLS*CELL_W-1:0] data_out
);

    logic [CELL_W-1:0] w_cells [NUM_CELLS];

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        logic [3:0] w_src;
        assign w_cells[gi] = data_in[gi*CELL_W +: CELL_W];
        assign w_src       = perm_src(perm_mode_e'(mode), 4'(gi));
        assign data_out[gi*CELL_W +: CELL_W] = w_cells[w_src];
    end

endmodule
`default_nettype wire

// File: rtl/cell_perm_engine.sv
`default_nettype none
// ============================================================================
// Module  : cell_perm_engine
// Brief   : Applies a selected cell permutation a programmable number of times.
// Revision: 1.0 - initial release
// ============================================================================
module cell_perm_engine
    import cell_perm_pkg::*;
#(
    parameter int CELL_W   = 4,
    parameter int MAX_ITER = 16,
    localparam int CNT_W   = $clog2(MAX_ITER + 1),
    localparam int DATA_W  = NUM_CELLS * CELL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic [CNT_W-1:0]  in_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            fsm_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mode_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [DATA_W-1:0] w_step_data;
    logic [CNT_W-1:0]  w_cnt_load;

    cell_perm_step #(
        .CELL_W (CELL_W)
    ) u_step (
        .data_in  (data_q),
        .mode     (mode_q),
        .data_out (w_step_data)
    );

    assign w_cnt_load = (in_count > CNT_W'(MAX_ITER)) ? CNT_W'(MAX_ITER) : in_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_data;
                        mode_q     <= in_mode;
                        cnt_q      <= w_cnt_load;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (w_cnt_load == '0) begin
                            fsm_q       <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            fsm_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    data_q <= w_step_data;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Return to IDLE without accepting; in_ready rises only afterwards.
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule
`default_nettype wire
